// File: rtl/fetch_controller.sv
// fetch_controller: owns the program counter, presents it to instruction memory,
// and registers each fetched instruction into a one-entry valid/ready output stage
// toward decode. It handles start, stall, redirect (branch/jump) and halt detection.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               leave IDLE and begin fetching
//   imem_addr           combinational read address (pc, zero-extended)
//   imem_instr          instruction returned combinationally for imem_addr
//   instr_out/instr_pc  registered instruction and its PC
//   instr_valid         output stage holds a live instruction
//   instr_ready         decode accepts the instruction this cycle
//   redirect/redirect_pc flush the output stage and reload pc
//   halted              sticky: the halt instruction has been delivered
//   fetch_count         number of completed handshakes since reset
module fetch_controller #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] START_PC   = 32'h0,
  parameter logic [8:0]  HALT_INSTR = 9'h1FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [8:0]  imem_instr,
  output logic [8:0]  instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INSTR_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [INSTR_W-1:0]  instr_out_n;
  logic [DATA_W-1:0]   instr_pc_n;
  logic                instr_valid_n;
  logic                halted_n;
  logic [DATA_W-1:0]   fetch_count_n;
  logic                halt_pending, halt_pending_n;
  logic                handshake;

  // Only the low ADDR_W bits of a redirect target are meaningful.
  logic unused_redirect_hi;
  assign unused_redirect_hi = ^redirect_pc[DATA_W-1:ADDR_W];

  // Memory sees the current pc with no register in between.
  assign imem_addr = DATA_W'(pc);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= START_PC[ADDR_W-1:0];
      instr_out    <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
      fetch_count  <= '0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      instr_out    <= instr_out_n;
      instr_pc     <= instr_pc_n;
      instr_valid  <= instr_valid_n;
      halted       <= halted_n;
      fetch_count  <= fetch_count_n;
      halt_pending <= halt_pending_n;
    end
  end

  // Next-state logic: redirect beats capture, capture beats stall.
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    instr_out_n    = instr_out;
    instr_pc_n     = instr_pc;
    instr_valid_n  = instr_valid;
    halted_n       = halted;
    fetch_count_n  = fetch_count;
    halt_pending_n = halt_pending;
    handshake      = instr_valid & instr_ready;

    case (state)
      IDLE: begin
        if (start) state_n = FETCH;
      end

      FETCH: begin
        // A handshake always counts; the stage empties unless refilled below.
        if (handshake) begin
          fetch_count_n = fetch_count + DATA_W'(1);
          instr_valid_n = 1'b0;
        end

        if (redirect) begin
          pc_n           = redirect_pc[ADDR_W-1:0];
          instr_valid_n  = 1'b0;
          halt_pending_n = 1'b0;
        end else if (!halt_pending && (!instr_valid || instr_ready)) begin
          instr_out_n   = imem_instr;
          instr_pc_n    = DATA_W'(pc);
          instr_valid_n = 1'b1;
          pc_n          = pc + ADDR_W'(1);
          if (imem_instr == HALT_INSTR) halt_pending_n = 1'b1;
        end else if (halt_pending && handshake) begin
          // The halt instruction itself has just been accepted by decode.
          state_n        = HALTED;
          halted_n       = 1'b1;
          halt_pending_n = 1'b0;
        end
      end

      HALTED: begin
        instr_valid_n = 1'b0;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: sequential fetch with halt, stall, redirect,
// PC wrap (second instance with START_PC near the top), redirect-vs-halt and reset.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, start, instr_ready, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, instr_pc, fetch_count;
  logic [8:0]  imem_instr, instr_out;
  logic        instr_valid, halted;

  logic        w_reset, w_start, w_ready, w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_imem_addr, w_instr_pc, w_fetch_count;
  logic [8:0]  w_imem_instr, w_instr_out;
  logic        w_instr_valid, w_halted;

  logic [8:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr   = mem[imem_addr[11:0]];
  assign w_imem_instr = mem[w_imem_addr[11:0]];

  fetch_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_controller #(.START_PC(32'hFFE)) dut_w (
    .clk(clk), .reset(w_reset), .start(w_start),
    .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .instr_out(w_instr_out), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
    .instr_ready(w_ready), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .halted(w_halted), .fetch_count(w_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 9'(i & 32'hFF);
    reset = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_reset = 1'b1; w_start = 1'b0; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;

    tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_out",   32'(instr_out),   32'd0);
    check("rst_pc",    instr_pc,         32'd0);
    check("rst_halt",  32'(halted),      32'd0);
    check("rst_count", fetch_count,      32'd0);
    check("rst_addr",  imem_addr,        32'd0);
    reset = 1'b0;

    // Sequential fetch ending in HALT at address 3.
    mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = 9'h1FF;
    start = 1'b1; instr_ready = 1'b1;
    tick(); start = 1'b0;
    check("t1_c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("t1_c2_valid", 32'(instr_valid), 32'd1);
    check("t1_pc0", instr_pc, 32'd0);
    check("t1_out0", 32'(instr_out), 32'h011);
    tick();
    check("t1_pc1", instr_pc, 32'd1);
    check("t1_out1", 32'(instr_out), 32'h022);
    tick();
    check("t1_pc2", instr_pc, 32'd2);
    tick();
    check("t1_pc3", instr_pc, 32'd3);
    check("t1_out3", 32'(instr_out), 32'h1FF);
    check("t1_nohalt", 32'(halted), 32'd0);
    tick();
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_hvalid", 32'(instr_valid), 32'd0);
    check("t1_count", fetch_count, 32'd4);
    start = 1'b1; redirect = 1'b1; redirect_pc = 32'h50;
    tick(); start = 1'b0; redirect = 1'b0;
    check("t1_hold_halt", 32'(halted), 32'd1);
    check("t1_hold_valid", 32'(instr_valid), 32'd0);
    check("t1_hold_addr", imem_addr, 32'd4);
    check("t1_hold_count", fetch_count, 32'd4);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("t6_rst_halted", 32'(halted), 32'd0);
    check("t6_rst_hcount", fetch_count, 32'd0);

    // Stall at pc 5.
    for (int i = 0; i < 4; i++) mem[i] = 9'(i);
    start = 1'b1; instr_ready = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();
    check("t2_pc5", instr_pc, 32'd5);
    check("t2_count5", fetch_count, 32'd5);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_pc", instr_pc, 32'd5);
      check("t2_stall_out", 32'(instr_out), 32'd5);
      check("t2_stall_addr", imem_addr, 32'd6);
      check("t2_stall_count", fetch_count, 32'd5);
      check("t2_stall_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    check("t2_pc6", instr_pc, 32'd6);
    check("t2_count6", fetch_count, 32'd6);

    // Redirect while stalled.
    instr_ready = 1'b0;
    tick();
    check("t3_stall_pc6", instr_pc, 32'd6);
    redirect = 1'b1; redirect_pc = 32'h20;
    tick(); redirect = 1'b0;
    check("t3_flush_valid", 32'(instr_valid), 32'd0);
    check("t3_flush_count", fetch_count, 32'd6);
    check("t3_flush_addr", imem_addr, 32'h20);
    tick();
    check("t3_tgt_valid", 32'(instr_valid), 32'd1);
    check("t3_tgt_pc", instr_pc, 32'h20);
    check("t3_tgt_out", 32'(instr_out), 32'h20);
    check("t3_tgt_count", fetch_count, 32'd6);
    redirect = 1'b1; redirect_pc = 32'h1020;
    tick(); redirect = 1'b0;
    check("t3_mask_valid", 32'(instr_valid), 32'd0);
    check("t3_mask_addr", imem_addr, 32'h20);
    tick();
    check("t3_mask_pc", instr_pc, 32'h20);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick(); redirect = 1'b0;
    check("t3_hs_redir_valid", 32'(instr_valid), 32'd0);
    check("t3_hs_redir_count", fetch_count, 32'd7);

    // Redirect in the same cycle the halt instruction is handed over.
    mem[12'h42] = 9'h1FF;
    tick();
    check("t5_pc40", instr_pc, 32'h40);
    tick();
    tick();
    check("t5_pc42", instr_pc, 32'h42);
    check("t5_count9", fetch_count, 32'd9);
    redirect = 1'b1; redirect_pc = 32'h10;
    tick(); redirect = 1'b0;
    check("t5_rd_valid", 32'(instr_valid), 32'd0);
    check("t5_rd_halted", 32'(halted), 32'd0);
    check("t5_rd_count", fetch_count, 32'd10);
    tick();
    check("t5_resume_pc", instr_pc, 32'h10);
    check("t5_resume_valid", 32'(instr_valid), 32'd1);
    check("t5_resume_halted", 32'(halted), 32'd0);

    // Start and redirect together in IDLE.
    reset = 1'b1;
    tick(); reset = 1'b0;
    start = 1'b1; redirect = 1'b1; redirect_pc = 32'h30;
    tick(); start = 1'b0; redirect = 1'b0;
    check("t5_idle_valid", 32'(instr_valid), 32'd0);
    check("t5_idle_addr", imem_addr, 32'd0);
    tick();
    check("t5_idle_first_pc", instr_pc, 32'd0);
    check("t5_idle_first_valid", 32'(instr_valid), 32'd1);

    // Reset mid-stream with seven transfers done.
    repeat (7) tick();
    check("t6_count7", fetch_count, 32'd7);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_out", 32'(instr_out), 32'd0);
    check("t6_pc", instr_pc, 32'd0);
    check("t6_count", fetch_count, 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_addr", imem_addr, 32'd0);
    repeat (3) tick();
    check("t6_idle_valid", 32'(instr_valid), 32'd0);
    check("t6_idle_addr", imem_addr, 32'd0);
    check("t6_idle_count", fetch_count, 32'd0);

    // PC wrap on the START_PC=0xFFE instance.
    tick(); w_reset = 1'b0;
    w_ready = 1'b1; w_start = 1'b1;
    tick(); w_start = 1'b0;
    tick();
    check("t4_pc_ffe", w_instr_pc, 32'hFFE);
    check("t4_out_ffe", 32'(w_instr_out), 32'hFE);
    tick();
    check("t4_pc_fff", w_instr_pc, 32'hFFF);
    tick();
    check("t4_pc_000", w_instr_pc, 32'h000);
    check("t4_out_000", 32'(w_instr_out), 32'h000);
    tick();
    check("t4_pc_001", w_instr_pc, 32'h001);
    check("t4_valid", 32'(w_instr_valid), 32'd1);
    check("t4_addr", w_imem_addr, 32'h002);
    check("t4_count", w_fetch_count, 32'd3);
    check("t4_halted", 32'(w_halted), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
